// File: rtl/boot_rom_reader.sv
// Boot ROM burst reader: turns word-aligned burst requests into single-cycle ROM
// reads and returns the beats through a 2-entry response FIFO.
module boot_rom_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [2:0]            req_len,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_last,
  output logic                  resp_error,
  output logic                  rom_me,
  output logic                  rom_oe,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_beats_left;
  logic                  r_inflight;
  logic                  r_inflight_last;

  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic                  r_fifo_last [2];
  logic                  r_fifo_err  [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_err_push;
  logic                  w_accept;
  logic                  w_aligned;
  logic [2:0]            w_occupancy;
  logic                  w_has_room;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic                  w_push_last;
  logic                  w_push_err;

  assign w_empty   = (r_count == 2'd0);
  assign w_pop     = !w_empty && resp_ready;
  assign w_accept  = req_valid && req_ready;
  assign w_aligned = (req_addr[1:0] == 2'b00);

  // A beat leaving this cycle frees its slot now, which is what lets a burst
  // stream one beat per cycle through only two entries.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_has_room  = (w_occupancy < 3'd2);

  // Gated by reset so the request side stays closed while reset is held.
  assign req_ready = (r_state == IDLE) && !reset;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    w_next_state = r_state;
    rom_me       = 1'b0;
    rom_address  = '0;
    w_err_push   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = w_aligned ? BURST : ERR;
      end
      BURST: begin
        if (w_has_room) begin
          rom_me      = 1'b1;
          rom_address = r_addr;
          if (r_beats_left == 4'd1) w_next_state = IDLE;
        end
      end
      ERR: begin
        if (w_has_room) begin
          w_err_push   = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Only one source pushes per cycle: ERR is entered from IDLE, by which time
  // the last in-flight capture of a previous burst has already landed.
  assign w_push      = r_inflight || w_err_push;
  assign w_push_data = r_inflight ? rom_q : '0;
  assign w_push_last = r_inflight ? r_inflight_last : 1'b1;
  assign w_push_err  = !r_inflight;

  // NOTE: state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_beats_left    <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_inflight      <= rom_me;
      r_inflight_last <= rom_me && (r_beats_left == 4'd1);
      if (w_accept && w_aligned) begin
        r_addr       <= req_addr[ADDR_WIDTH+1:2];
        r_beats_left <= {1'b0, req_len} + 4'd1;
      end else if (rom_me) begin
        r_addr       <= r_addr + 1'b1;
        r_beats_left <= r_beats_left - 4'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= !r_wr_ptr;
      if (w_pop)  r_rd_ptr <= !r_rd_ptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count are, and the
  // outputs below are forced to zero while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= w_push_data;
      r_fifo_last[r_wr_ptr] <= w_push_last;
      r_fifo_err[r_wr_ptr]  <= w_push_err;
    end
  end

  assign resp_valid = !w_empty;
  assign resp_data  = w_empty ? '0 : r_fifo_data[r_rd_ptr];
  assign resp_last  = !w_empty && r_fifo_last[r_rd_ptr];
  assign resp_error = !w_empty && r_fifo_err[r_rd_ptr];
  assign rom_oe     = r_inflight;

endmodule

// File: tb/tb_boot_rom_reader.sv
// Scoreboard bench for boot_rom_reader: a behavioural ROM answers reads, and the
// expected beats queued per request are compared as the DUT hands them over.
module tb_boot_rom_reader;

  localparam int AW = 11;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW+1:0] req_addr = '0;
  logic [2:0]    req_len = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_data;
  logic          resp_last;
  logic          resp_error;
  logic          rom_me;
  logic          rom_oe;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_q = '0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          err;
  } beat_t;

  beat_t exp_q[$];
  int    n_compared   = 0;
  int    n_mismatched = 0;
  int    n_issued     = 0;
  int    n_rom_pops   = 0;
  int    max_out      = 0;
  int    addr_viol    = 0;
  logic  hold_pending = 1'b0;
  beat_t hold_beat;

  boot_rom_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_last   (resp_last),
    .resp_error  (resp_error),
    .rom_me      (rom_me),
    .rom_oe      (rom_oe),
    .rom_address (rom_address),
    .rom_q       (rom_q)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {5'h15, a, 5'h0A, ~a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // ROM with one cycle of read latency.
  always @(posedge clock) if (rom_me) rom_q <= rom_word(rom_address);

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      n_issued   <= 0;
      n_rom_pops <= 0;
    end else begin
      if (rom_me) n_issued <= n_issued + 1;
      if (resp_valid && resp_ready && !resp_error) n_rom_pops <= n_rom_pops + 1;
    end
  end

  // Response monitor: pops the scoreboard on each handshake, checks hold stability.
  always @(negedge clock) begin
    if (reset) begin
      hold_pending <= 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 64'(resp_valid), 64'd1);
        check("hold_beat", 64'({resp_data, resp_last, resp_error}), 64'(hold_beat));
      end
      if (resp_valid && resp_ready) begin
        check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat", 64'({resp_data, resp_last, resp_error}), 64'(b));
        end
      end
      hold_pending <= resp_valid && !resp_ready;
      hold_beat    <= {resp_data, resp_last, resp_error};
      if (n_issued - n_rom_pops > max_out) max_out <= n_issued - n_rom_pops;
      if (!rom_me && rom_address != '0) addr_viol <= addr_viol + 1;
    end
  end

  task automatic send(input logic [AW+1:0] a, input logic [2:0] l);
    int guard = 0;
    logic [AW-1:0] w;
    @(negedge clock);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    if (a[1:0] != 2'b00) begin
      exp_q.push_back('{data: '0, last: 1'b1, err: 1'b1});
    end else begin
      w = a[AW+1:2];
      for (int i = 0; i <= int'(l); i++) begin
        exp_q.push_back('{data: rom_word(w), last: (i == int'(l)), err: 1'b0});
        w = w + 1'b1;
      end
    end
    while (!req_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    check("req_ready_seen", 64'(req_ready), 64'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || resp_valid) && guard < 100) begin
      @(negedge clock);
      #1 guard++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;

    repeat (3) @(posedge clock);
    #2;
    check("reset_outputs", 64'({req_ready, resp_valid, resp_last, resp_error, rom_me, rom_oe,
                                rom_address, resp_data}), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 64'(req_ready), 64'd1);
    check("valid_after_reset", 64'(resp_valid), 64'd0);

    // Four-beat burst: latency and back-to-back streaming.
    send(14'h0010, 3'd3);
    n = 0;
    while (!resp_valid && n < 10) begin
      @(posedge clock);
      #1 n++;
    end
    check("t1_latency", 64'(n), 64'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("t1_stream%0d", i), 64'(resp_valid), 64'd1);
    end
    drain();

    // Address wraps from the top word back to zero.
    send(14'h1FFC, 3'd2);
    drain();

    // Eight beats with the consumer stalled for five cycles.
    resp_ready = 1'b0;
    send(14'h0000, 3'd7);
    repeat (5) @(posedge clock);
    #1;
    check("t3_full_valid", 64'(resp_valid), 64'd1);
    check("t3_no_overrun", 64'(n_issued - n_rom_pops), 64'd2);
    resp_ready = 1'b1;
    drain();

    // Misaligned request: error beat, no ROM traffic.
    base = n_issued;
    send(14'h0006, 3'd0);
    drain();
    check("t4_no_rom_read", 64'(n_issued - base), 64'd0);

    // Reset in the middle of an eight-beat burst.
    base = n_rom_pops;
    send(14'h0040, 3'd7);
    n = 0;
    while (n_rom_pops - base < 3 && n < 30) begin
      @(posedge clock);
      #1 n++;
    end
    check("t5_three_beats", 64'(n_rom_pops - base), 64'd3);
    #2 reset = 1'b1;
    #1;
    check("t5_reset_outputs", 64'({req_ready, resp_valid, resp_last, resp_error, rom_me, rom_oe,
                                   rom_address, resp_data}), 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("t5_ready_after", 64'(req_ready), 64'd1);
    check("t5_valid_after", 64'(resp_valid), 64'd0);
    repeat (10) @(negedge clock);
    check("t5_no_stale_read", 64'(n_issued), 64'd0);
    check("t5_no_stale_beat", 64'(resp_valid), 64'd0);

    // Back-to-back single-beat requests.
    send(14'h0000, 3'd0);
    send(14'h0004, 3'd0);
    drain();

    check("max_outstanding_le2", 64'(max_out <= 2), 64'd1);
    check("rom_addr_idle_zero", 64'(addr_viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
